// File: rtl/reg_arb_pkg.sv
// Shared constants and round-robin helpers for the register access arbiter.
package reg_arb_pkg;

    localparam int MIN_DATA_WIDTH = 8;
    localparam int MAX_DATA_WIDTH = 32;
    localparam int MAX_NUM_REQ    = 8;
    localparam int PTR_W          = $clog2(MAX_NUM_REQ);

    // First set bit of cand at or after ptr, wrapping within the first n bits.
    function automatic logic [MAX_NUM_REQ-1:0] rr_pick(
        input logic [MAX_NUM_REQ-1:0] cand,
        input logic [PTR_W-1:0]       ptr,
        input int                     n
    );
        logic [MAX_NUM_REQ-1:0] grant;
        logic                   found;
        int                     idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && cand[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_data_reg.sv
// Storage register shared by all requesters; written only through the arbiter.
module shared_data_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else if (we) q <= d;
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting one write and one read per cycle to a shared register.
// Optional write lock ownership is compiled in with the ARB_LOCK_EN macro.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [DATA_WIDTH-1:0]         reg_q
`ifdef ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic                          lock_owner_valid,
    output logic [$clog2(NUM_REQ)-1:0]    lock_owner
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a request transfers at a rising edge where req_valid[i] & req_ready[i];
    // req_ready depends combinationally on req_valid/req_write and is 0 during reset.
    logic [IDX_W-1:0]       wr_ptr, rd_ptr;
    logic [NUM_REQ-1:0]     wr_mask, wr_cand, rd_cand, wr_grant, rd_grant;
    logic [MAX_NUM_REQ-1:0] wr_pick, rd_pick;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic                   wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0]  wr_data, rd_fwd;

`ifdef ARB_LOCK_EN
    assign wr_mask = lock_owner_valid ? (NUM_REQ'(1) << lock_owner) : '1;
`else
    assign wr_mask = '1;
`endif

    always_comb begin
        wr_cand  = req_valid & req_write & wr_mask;
        rd_cand  = req_valid & ~req_write;
        wr_pick  = rr_pick(MAX_NUM_REQ'(wr_cand), PTR_W'(wr_ptr), NUM_REQ);
        rd_pick  = rr_pick(MAX_NUM_REQ'(rd_cand), PTR_W'(rd_ptr), NUM_REQ);
        wr_grant = reset ? '0 : wr_pick[NUM_REQ-1:0];
        rd_grant = reset ? '0 : rd_pick[NUM_REQ-1:0];
        wr_idx   = IDX_W'(onehot_to_idx(wr_pick));
        rd_idx   = IDX_W'(onehot_to_idx(rd_pick));
        wr_fire  = |wr_grant;
        rd_fire  = |rd_grant;
        wr_data  = req_wdata[wr_idx*DATA_WIDTH +: DATA_WIDTH];
        // Write-first: a read accepted alongside a write sees the new value.
        rd_fwd   = wr_fire ? wr_data : reg_q;
    end

    assign req_ready = wr_grant | rd_grant;

    shared_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (wr_fire),
        .d     (wr_data),
        .q     (reg_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= (wr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : wr_idx + 1'b1;
            if (rd_fire) rd_ptr <= (rd_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_grant;
            if (rd_fire) rsp_rdata <= rd_fwd;
        end
    end

`ifdef ARB_LOCK_EN
    // Only the owner can be granted while locked, so any unlocking write releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_owner_valid <= 1'b0;
            lock_owner       <= '0;
        end else if (wr_fire) begin
            if (req_lock[wr_idx]) begin
                lock_owner_valid <= 1'b1;
                lock_owner       <= wr_idx;
            end else if (lock_owner_valid && wr_idx == lock_owner) begin
                lock_owner_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Randomised and directed bench for reg_access_arbiter with a queue-based response scoreboard.
module tb_reg_access_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, reg_q;
`ifdef ARB_LOCK_EN
    logic            lock_owner_valid;
    logic [IW-1:0]   lock_owner;
`endif

    reg_access_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .reg_q     (reg_q)
`ifdef ARB_LOCK_EN
        ,
        .req_lock         (req_lock),
        .lock_owner_valid (lock_owner_valid),
        .lock_owner       (lock_owner)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entries: {responding requester index, read data}
    logic [IW+DW-1:0] exp_q[$];

    // Reference model state
    logic [DW-1:0] m_store;
    int            m_wr_ptr, m_rd_ptr, m_owner;
    bit            m_lock;
    bit            p_valid[N], p_write[N], p_lock[N];
    logic [DW-1:0] p_data[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit cand[N], input int ptr);
        for (int k = 0; k < N; k++) begin
            if (cand[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]               = p_valid[i];
            req_write[i]               = p_write[i];
            req_lock[i]                = p_lock[i];
            req_wdata[i*DW +: DW]      = p_data[i];
        end
    endtask

    task automatic clear_pending();
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0;
            p_write[i] = 1'b0;
            p_lock[i]  = 1'b0;
            p_data[i]  = '0;
        end
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic cycle();
        bit            wc[N], rc[N];
        int            wg, rg;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] rdata;
        apply();
        #1;
        for (int i = 0; i < N; i++) begin
            wc[i] = p_valid[i] && p_write[i] && (!m_lock || i == m_owner);
            rc[i] = p_valid[i] && !p_write[i];
        end
        wg = pick(wc, m_wr_ptr);
        rg = pick(rc, m_rd_ptr);
        exp_ready = '0;
        if (wg >= 0) exp_ready[wg] = 1'b1;
        if (rg >= 0) exp_ready[rg] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        rdata = (wg >= 0) ? p_data[wg] : m_store;
        @(posedge clk);
        if (wg >= 0) begin
            m_store  = p_data[wg];
            m_wr_ptr = (wg + 1) % N;
            if (p_lock[wg]) begin
                m_lock  = 1'b1;
                m_owner = wg;
            end else if (m_lock && wg == m_owner) begin
                m_lock = 1'b0;
            end
            p_valid[wg] = 1'b0;
        end
        if (rg >= 0) begin
            m_rd_ptr = (rg + 1) % N;
            p_valid[rg] = 1'b0;
            exp_q.push_back({IW'(rg), rdata});
        end
        #1;
        check("reg_q", 32'(reg_q), 32'(m_store));
`ifdef ARB_LOCK_EN
        check("lock_owner_valid", 32'(lock_owner_valid), 32'(m_lock));
        if (m_lock) check("lock_owner", 32'(lock_owner), 32'(m_owner));
`endif
    endtask

    task automatic reset_dut(input int n);
        reset     = 1'b1;
        req_valid = '1;
        req_write = 4'b0101;
        req_lock  = '0;
        req_wdata = $urandom;
        clear_pending();
        m_store  = '0;
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        m_lock   = 1'b0;
        m_owner  = 0;
        exp_q.delete();
        repeat (n) begin
            @(negedge clk);
            check("reset_req_ready", 32'(req_ready), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            check("reset_reg_q", 32'(reg_q), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply();
    endtask

    task automatic set_req(input int i, input bit wr, input logic [DW-1:0] d, input bit lk);
        p_valid[i] = 1'b1;
        p_write[i] = wr;
        p_data[i]  = d;
        p_lock[i]  = lk;
    endtask

    // Monitor: every response must match the oldest expected entry, exactly one cycle later.
    always @(negedge clk) begin
        logic [IW+DW-1:0] e;
        logic [N-1:0]     exp_oh;
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e      = exp_q.pop_front();
                exp_oh = N'(1) << e[IW+DW-1:DW];
                check("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
                check("rsp_rdata", 32'(rsp_rdata), 32'(e[DW-1:0]));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_missing", 32'(rsp_valid), 32'(N'(1) << e[IW+DW-1:DW]));
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_lock  = '0;
        req_wdata = '0;
        clear_pending();

        // Reset, then idle with no requests
        reset_dut(3);
        repeat (3) cycle();

        // Single write by requester 0
        set_req(0, 1'b1, 8'hA5, 1'b0);
        cycle();
        check("t2_reg_q", 32'(reg_q), 32'hA5);

        // Four held writes served in rotation
        reset_dut(1);
        set_req(0, 1'b1, 8'h11, 1'b0);
        set_req(1, 1'b1, 8'h22, 1'b0);
        set_req(2, 1'b1, 8'h33, 1'b0);
        set_req(3, 1'b1, 8'h44, 1'b0);
        repeat (4) cycle();
        check("t3_reg_q", 32'(reg_q), 32'h44);

        // Concurrent write and read, read sees the written value
        set_req(0, 1'b1, 8'hA5, 1'b0);
        cycle();
        set_req(1, 1'b1, 8'h3C, 1'b0);
        set_req(2, 1'b0, 8'h00, 1'b0);
        cycle();
        check("t4_reg_q", 32'(reg_q), 32'h3C);
        cycle();

        // Two reads with rd_ptr at zero
        reset_dut(1);
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);
        repeat (3) cycle();

        // Reset while a read response is in flight
        set_req(1, 1'b1, 8'h5A, 1'b0);
        cycle();
        set_req(2, 1'b0, 8'h00, 1'b0);
        cycle();
        reset_dut(1);
        repeat (2) cycle();

`ifdef ARB_LOCK_EN
        // Lock ownership blocks other writers until released
        set_req(1, 1'b1, 8'h55, 1'b1);
        cycle();
        set_req(2, 1'b1, 8'h66, 1'b0);
        repeat (3) cycle();
        check("lock_blocks_req2", 32'(req_ready), 32'd0);
        set_req(1, 1'b1, 8'h77, 1'b0);
        repeat (3) cycle();
        check("lock_final_reg_q", 32'(reg_q), 32'h66);
`endif

        // Randomised traffic with holding requesters and occasional withdrawals
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_valid[i]) begin
                    if ($urandom_range(0, 99) < 60)
                        set_req(i, 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
                end else if ($urandom_range(0, 99) < 3) begin
                    p_valid[i] = 1'b0;
                end
            end
            cycle();
        end

        clear_pending();
        repeat (2) cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares one DATA_WIDTH-bit storage register between NUM_REQ requesters.
- Arbitrates writes and reads independently, round-robin within each class.
- Per cycle, accepts at most one write and one read; a read and a write may proceed together.
- When both happen in the same cycle, the write takes priority: the read returns the newly written value.
- Sits between processor-side requesters and the storage register. The storage register is instantiated internally.

Parameters:
DATA_WIDTH, 8, storage/data width; legal 8..32.
NUM_REQ, 4, number of requesters; legal 2..8.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request pending.
req_write  in  NUM_REQ  per-requester op: 1=write, 0=read; qualified by req_valid.
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  out  NUM_REQ  combinational accept; valid&ready at a rising edge = accepted.
rsp_valid  out  NUM_REQ  registered one-hot read-response pulse.
rsp_rdata  out  DATA_WIDTH  registered read data.
reg_q  out  DATA_WIDTH  current stored value.

Behaviour:
- Reset (async):
  - storage=0, reg_q=0.
  - wr_ptr=0, rd_ptr=0.
  - rsp_valid=0, rsp_rdata=0.
  - req_ready=0 while reset is high.
- Request classes:
  - Write candidates: req_valid & req_write.
  - Read candidates: req_valid & ~req_write.
- Write grant: first write candidate found scanning from wr_ptr upward, wrapping modulo NUM_REQ. Read grant uses the same scan from rd_ptr over read candidates.
- req_ready is the OR of the two one-hot grants. It is at most two-hot, never two bits from the same class.
- Accepted write: storage <= granted req_wdata at the same edge, so reg_q updates 1 cycle after accept.
- Accepted read:
  - Next cycle: rsp_valid[granted]=1 for exactly one cycle.
  - rsp_rdata = storage value after that edge's write. A same-cycle write is forwarded (write-first).
- rsp_rdata holds its last value while rsp_valid=0.
- Pointer update: on a grant, that class's ptr <= granted index + 1 (mod NUM_REQ). With no grant in the class, the ptr holds. The two pointers are independent.
- Fairness: continuously asserted same-class requesters are served in strict rotation. Worst-case wait is NUM_REQ-1 cycles.
- Requesters hold valid/write/wdata stable until accepted. Dropping valid before accept is legal; no state change results.
- No request pending: no state change except rsp_valid returns to 0.
- Reset mid-operation: an in-flight response is dropped (rsp_valid forced 0) and storage clears. Requesters must reissue.
- Read response latency: fixed at 1 cycle. Throughput: 1 write + 1 read per cycle.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Enabled:
  - Adds input req_lock [NUM_REQ] and output lock_owner_valid (1) plus lock_owner (clog2(NUM_REQ)).
  - An accepted write with req_lock=1 makes that requester lock owner.
  - While a lock is held, write candidates from non-owners are masked. Reads are unaffected.
  - The owner releases the lock with an accepted write carrying req_lock=0.
  - Reset clears the lock.
- Disabled: no lock ports, and arbitration is unmasked.

Decomposition:
- Package reg_arb_pkg:
  - MIN_DATA_WIDTH=8, MAX_DATA_WIDTH=32, MAX_NUM_REQ=8.
  - Function rr_pick(candidates, ptr) returning a one-hot grant.
  - Function onehot_to_idx.
- Sub-module shared_data_reg: DATA_WIDTH storage with clk, async reset, write enable, write data, and q output. The arbiter instantiates it once.

Test Plan:
1. Assert reset for 3 cycles, then release with no requests -> reg_q=0, rsp_valid=0, req_ready=0 throughout.
2. req0 writes 0xA5 -> req_ready[0]=1 in the same cycle; reg_q=0xA5 next cycle; wr_ptr=1.
3. All 4 requesters hold valid writes (0x11,0x22,0x33,0x44) until each is accepted -> grants in order 0,1,2,3, one per cycle; final reg_q=0x44.
4. reg_q=0xA5; in one cycle req1 writes 0x3C and req2 reads -> req_ready=4'b0110; next cycle rsp_valid=4'b0100, rsp_rdata=0x3C, reg_q=0x3C.
5. req0 and req3 read simultaneously with rd_ptr=0 -> req0 is accepted first and req3 the next cycle; rsp_valid shows 0001 then 1000.
6. Read accepted, then reset pulses before the next edge -> rsp_valid stays 0 and reg_q=0. With ARB_LOCK_EN defined, req1 write with lock=1 followed by a req2 write -> req2 is blocked until req1 writes with lock=0.
